data_memory_responder: RTL and testbench

DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

---
 rtl/data_memory_responder.sv | 177 +++++++++++++++++
 tb/tb_data_memory_responder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - byte-addressable data memory with a fixed-latency BUSYWAIT handshake
//
// Ports:
//   CLK        single clock, all state updates on the rising edge
//   RESET      asynchronous active-low reset (clears FSM, READDATA and storage)
//   READ[3:0]  bit3 = load enable, bits2:0 = funct3 (LB/LH/LW/LBU/LHU)
//   WRITE[2:0] bit2 = store enable, bits1:0 = size (SB/SH/SW)
//   ADDRESS    byte address of the access
//   WRITEDATA  store data, right-aligned
//   READDATA   registered load result, extended to 32 bits
//   BUSYWAIT   combinational stall: high while a request is present and not in ACK

module data_memory_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [3:0]  READ,
    input  logic [2:0]  WRITE,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITEDATA,
    output logic [31:0] READDATA,
    output logic        BUSYWAIT
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CAP_W = IDX_W + 2;
    // Counter value on the last BUSY cycle; BUSY is entered with count = 1.
    localparam logic [3:0] LAST_COUNT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_ACK
    } state_t;

    state_t             state;
    logic [3:0]         count;
    logic [3:0]         cap_read;
    logic [2:0]         cap_write;
    logic [CAP_W-1:0]   cap_addr;
    logic [31:0]        cap_wdata;

    logic [31:0]        mem [DEPTH_WORDS];

    logic               request;
    logic               finishing;
    logic [IDX_W-1:0]   word_idx;
    logic [31:0]        cur_word;
    logic [3:0]         byte_en;
    logic [31:0]        lane_data;
    logic [31:0]        merged_word;
    logic [7:0]         sel_byte;
    logic [15:0]        sel_half;
    logic [31:0]        load_value;

    // Address bits above the word index alias onto the same storage.
    logic               unused_addr_bits;
    assign unused_addr_bits = ^ADDRESS[31:CAP_W];

    assign request   = READ[3] | WRITE[2];
    assign BUSYWAIT  = request && (state != S_ACK);
    assign finishing = (state == S_BUSY) && (count == LAST_COUNT);

    assign word_idx  = cap_addr[CAP_W-1:2];
    assign cur_word  = mem[word_idx];

    // Store lane selection and merge with the existing word.
    always_comb begin
        byte_en   = 4'b1111;
        lane_data = cap_wdata;
        case (cap_write[1:0])
            2'b00: begin
                byte_en   = 4'b0001 << cap_addr[1:0];
                lane_data = {4{cap_wdata[7:0]}};
            end
            2'b01: begin
                byte_en   = cap_addr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{cap_wdata[15:0]}};
            end
            default: begin
                // SW, and the unused size code 11 is treated as a full word.
                byte_en   = 4'b1111;
                lane_data = cap_wdata;
            end
        endcase
        merged_word = cur_word;
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) begin
                merged_word[8*i +: 8] = lane_data[8*i +: 8];
            end
        end
    end

    // Load lane extraction and extension.
    always_comb begin
        sel_byte = cur_word[7:0];
        case (cap_addr[1:0])
            2'b00:   sel_byte = cur_word[7:0];
            2'b01:   sel_byte = cur_word[15:8];
            2'b10:   sel_byte = cur_word[23:16];
            default: sel_byte = cur_word[31:24];
        endcase
        sel_half = cap_addr[1] ? cur_word[31:16] : cur_word[15:0];

        case (cap_read[2:0])
            3'b000:  load_value = {{24{sel_byte[7]}}, sel_byte};
            3'b001:  load_value = {{16{sel_half[15]}}, sel_half};
            3'b100:  load_value = {24'h000000, sel_byte};
            3'b101:  load_value = {16'h0000, sel_half};
            default: load_value = cur_word;  // LW and undefined funct3 codes
        endcase
    end

    // Handshake FSM, request capture and registered load result.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= S_IDLE;
            count     <= 4'd0;
            cap_read  <= 4'd0;
            cap_write <= 3'd0;
            cap_addr  <= '0;
            cap_wdata <= 32'd0;
            READDATA  <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (request) begin
                        cap_read  <= READ;
                        cap_write <= WRITE;
                        cap_addr  <= ADDRESS[CAP_W-1:0];
                        cap_wdata <= WRITEDATA;
                        count     <= 4'd1;
                        state     <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (count == LAST_COUNT) begin
                        count <= 4'd0;
                        state <= S_ACK;
                        // A combined read+write performs the store and reports 0;
                        // a pure store leaves the last load result in place.
                        if (cap_write[2]) begin
                            if (cap_read[3]) begin
                                READDATA <= 32'd0;
                            end
                        end else if (cap_read[3]) begin
                            READDATA <= load_value;
                        end
                    end else begin
                        count <= count + 4'd1;
                    end
                end
                S_ACK: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    count <= 4'd0;
                end
            endcase
        end
    end

    // Storage: cleared by reset, stores commit on the BUSY->ACK edge only.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= 32'd0;
            end
        end else if (finishing && cap_write[2]) begin
            mem[word_idx] <= merged_word;
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// tb/tb_data_memory_responder.sv - scoreboard bench for data_memory_responder

module tb_data_memory_responder;

    localparam int LAT = 4;

    logic        CLK;
    logic        RESET;
    logic [3:0]  READ;
    logic [2:0]  WRITE;
    logic [31:0] ADDRESS;
    logic [31:0] WRITEDATA;
    logic [31:0] READDATA;
    logic        BUSYWAIT;

    data_memory_responder #(
        .DEPTH_WORDS(256),
        .LATENCY    (LAT)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .READ     (READ),
        .WRITE    (WRITE),
        .ADDRESS  (ADDRESS),
        .WRITEDATA(WRITEDATA),
        .READDATA (READDATA),
        .BUSYWAIT (BUSYWAIT)
    );

    typedef struct {
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_load = 32'd0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: an ACK cycle is a present request with BUSYWAIT low.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RESET && (READ[3] || WRITE[2]) && BUSYWAIT === 1'b0) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack actual=%h required=no_ack", READDATA);
                end else begin
                    e = sb.pop_front();
                    check(e.name, READDATA, e.val);
                end
            end
        end
    end

    task automatic issue(input logic [3:0] rd, input logic [2:0] wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp, input string name,
                         input bit push);
        @(posedge CLK);
        #1;
        READ      = rd;
        WRITE     = wr;
        ADDRESS   = addr;
        WRITEDATA = wdata;
        if (push) sb.push_back('{exp, name});
    endtask

    // Counts BUSYWAIT-high samples until the ACK sample; bounded.
    task automatic wait_ack(input string name, output int n);
        bit done;
        n    = 0;
        done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge CLK);
            if (BUSYWAIT) n++;
            else done = 1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=%0d required=ack", name, n);
        end
    endtask

    task automatic finish_access(input string name, input int already);
        int n;
        wait_ack(name, n);
        check({name, "_busy_cycles"}, 32'(n + already), 32'(LAT));
    endtask

    task automatic ld(input logic [3:0] rd, input logic [31:0] addr,
                      input logic [31:0] exp, input string name);
        issue(rd, 3'b000, addr, 32'd0, exp, name, 1);
        last_load = exp;
        finish_access(name, 0);
    endtask

    task automatic st(input logic [2:0] wr, input logic [31:0] addr,
                      input logic [31:0] data, input string name);
        issue(4'b0000, wr, addr, data, last_load, name, 1);
        finish_access(name, 0);
    endtask

    task automatic idle();
        @(posedge CLK);
        #1;
        READ  = 4'b0000;
        WRITE = 3'b000;
    endtask

    initial begin
        int n;
        RESET     = 1'b0;
        READ      = 4'b0000;
        WRITE     = 3'b000;
        ADDRESS   = 32'd0;
        WRITEDATA = 32'd0;
        repeat (2) @(negedge CLK);
        check("reset_readdata", READDATA, 32'd0);
        check("reset_busywait_idle", {31'd0, BUSYWAIT}, 32'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b1;

        // Basic word store / load
        st(3'b110, 32'h10, 32'hDEADBEEF, "sw_10");            idle();
        ld(4'b1010, 32'h10, 32'hDEADBEEF, "lw_10");           idle();

        // Sub-word loads with extension
        st(3'b110, 32'h20, 32'h80F07F01, "sw_20");            idle();
        ld(4'b1000, 32'h23, 32'hFFFFFF80, "lb_23");           idle();
        ld(4'b1100, 32'h23, 32'h00000080, "lbu_23");          idle();
        ld(4'b1001, 32'h22, 32'hFFFF80F0, "lh_22");           idle();
        ld(4'b1101, 32'h20, 32'h00007F01, "lhu_20");          idle();
        ld(4'b1011, 32'h21, 32'h80F07F01, "undef_funct3");    idle();

        // Sub-word stores touch only their lanes
        st(3'b110, 32'h20, 32'h11223344, "sw_20b");           idle();
        st(3'b100, 32'h21, 32'h123456AB, "sb_21");            idle();
        ld(4'b1010, 32'h20, 32'h1122AB44, "lw_after_sb");     idle();
        st(3'b101, 32'h23, 32'h5555CAFE, "sh_22");            idle();
        ld(4'b1010, 32'h20, 32'hCAFEAB44, "lw_after_sh");     idle();

        // Aliasing above the word index, and read+write together
        st(3'b110, 32'h400, 32'h00000055, "sw_400");          idle();
        ld(4'b1010, 32'h000, 32'h00000055, "lw_alias_0");     idle();
        issue(4'b1010, 3'b110, 32'h30, 32'h00000077, 32'd0, "rw_both", 1);
        last_load = 32'd0;
        finish_access("rw_both", 0);                          idle();
        ld(4'b1010, 32'h30, 32'h00000077, "lw_after_rw");     idle();

        // Reset in cycle 2 of a store, request dropped during reset
        issue(4'b0000, 3'b110, 32'h8, 32'h00001234, 32'd0, "sw_abort", 0);
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        check("rst_busy_with_req", {31'd0, BUSYWAIT}, 32'd1);
        check("rst_readdata_mid", READDATA, 32'd0);
        READ  = 4'b0000;
        WRITE = 3'b000;
        #1;
        check("rst_busy_no_req", {31'd0, BUSYWAIT}, 32'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        last_load = 32'd0;
        ld(4'b1010, 32'h8, 32'h00000000, "lw_8_after_abort"); idle();

        // Held request across reset restarts with full latency
        st(3'b110, 32'h0, 32'h0BADF00D, "sw_0");              idle();
        issue(4'b1010, 3'b000, 32'h0, 32'd0, 32'd0, "lw_held_rst", 1);
        last_load = 32'd0;
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        finish_access("lw_held_rst", 0);                      idle();

        // Back-to-back loads with no idle gap, then address change during BUSY
        st(3'b110, 32'h0, 32'h0BADF00D, "sw_0b");             idle();
        st(3'b110, 32'h10, 32'h13579BDF, "sw_10b");           idle();
        ld(4'b1010, 32'h0, 32'h0BADF00D, "lw_b2b_1");
        ld(4'b1010, 32'h0, 32'h0BADF00D, "lw_b2b_2");         idle();
        issue(4'b1010, 3'b000, 32'h0, 32'd0, 32'h0BADF00D, "lw_addr_change", 1);
        @(negedge CLK);
        @(negedge CLK);
        ADDRESS = 32'h10;
        finish_access("lw_addr_change", 2);                   idle();

        repeat (4) @(negedge CLK);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
